// File: rtl/div_unit_pkg.sv
// Shared constants, op codes, FSM state type and sign helpers for the RV32M divide unit.
package div_unit_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [XLEN-1:0] ZeroWord = '0;
  localparam logic [4:0]      ZeroReg  = '0;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return {XLEN{1'b0}} - v;
  endfunction

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? negate(v) : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage <-> divide-unit connection: launch request, writeback result and FSM debug state.
interface div_unit_if;
  import div_unit_pkg::*;

  // Handshake: start_i is a request taken only while the unit is IDLE and flush_i is low
  // (otherwise dropped, never queued); ready_o/rd_wen_o is a one-cycle valid with no backpressure.
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            busy_o;
  logic            ready_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_addr_o;
  logic            rd_wen_o;
  div_state_e      state_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
    input  busy_o, ready_o, result_o, rd_addr_o, rd_wen_o, state_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
    output busy_o, ready_o, result_o, rd_addr_o, rd_wen_o, state_o
  );

endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_SPECIAL_BYPASS_EN to send divide-by-zero and signed overflow straight from IDLE to DONE.
module div_unit
  import div_unit_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  div_unit_if.slave bus
);

  div_state_e       state_q, state_d;
  logic [XLEN:0]    rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  div_q, div_d;
  logic [XLEN-1:0]  dvd_q, dvd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [4:0]       rd_out_q, rd_out_d;

  logic             in_signed, in_zero, in_ovf, ready;
  logic [XLEN+1:0]  diff;
  logic [XLEN-1:0]  q_fix, r_fix, fix;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    dvd_d     = dvd_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;
    ready     = 1'b0;

    in_signed = (bus.op_i == DIV_OP_DIV) || (bus.op_i == DIV_OP_REM);
    in_zero   = (bus.divisor_i == ZeroWord);
    in_ovf    = in_signed && (bus.dividend_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                (bus.divisor_i == {XLEN{1'b1}});

    // Subtract against the one-bit-shifted partial remainder; the extra top bit is the borrow.
    diff = {rem_q, quo_q[XLEN-1]} - {2'b00, div_q};

    // Magnitude result with sign fix-up, then RISC-V special cases override it.
    q_fix = neg_quo_q ? negate(quo_q) : quo_q;
    r_fix = neg_rem_q ? negate(rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];
    if (zero_q) begin
      q_fix = {XLEN{1'b1}};
      r_fix = dvd_q;
    end else if (ovf_q) begin
      q_fix = {1'b1, {(XLEN-1){1'b0}}};
      r_fix = ZeroWord;
    end
    fix = ((op_q == DIV_OP_REM) || (op_q == DIV_OP_REMU)) ? r_fix : q_fix;

    case (state_q)
      DIV_IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          op_d      = bus.op_i;
          rd_d      = bus.rd_addr_i;
          quo_d     = abs_val(bus.dividend_i, in_signed);
          div_d     = abs_val(bus.divisor_i, in_signed);
          dvd_d     = bus.dividend_i;
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = in_signed && (bus.dividend_i[XLEN-1] ^ bus.divisor_i[XLEN-1]);
          neg_rem_d = in_signed && bus.dividend_i[XLEN-1];
          zero_d    = in_zero;
          ovf_d     = in_ovf;
`ifdef DIV_SPECIAL_BYPASS_EN
          state_d   = (in_zero || in_ovf) ? DIV_DONE : DIV_CALC;
`else
          state_d   = DIV_CALC;
`endif
        end
      end
      DIV_CALC: begin
        if (bus.flush_i) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = diff[XLEN+1] ? {rem_q[XLEN-1:0], quo_q[XLEN-1]} : diff[XLEN:0];
          quo_d = {quo_q[XLEN-2:0], ~diff[XLEN+1]};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
        if (!bus.flush_i) begin
          ready    = 1'b1;
          result_d = fix;
          rd_out_d = rd_q;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DIV_IDLE;
      rem_q     <= '0;
      quo_q     <= ZeroWord;
      div_q     <= ZeroWord;
      dvd_q     <= ZeroWord;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= ZeroReg;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= ZeroWord;
      rd_out_q  <= ZeroReg;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      dvd_q     <= dvd_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  assign bus.busy_o    = (state_q != DIV_IDLE);
  assign bus.ready_o   = ready;
  assign bus.rd_wen_o  = ready;
  assign bus.result_o  = ready ? fix : result_q;
  assign bus.rd_addr_o = ready ? rd_q : rd_out_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M vectors, random ops, flush, ignored start, async reset.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  div_unit_if bus ();

  div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  // Reference: RISC-V M-extension rules in plain arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic is_signed;
    logic is_rem;
    logic [31:0] q;
    logic [31:0] r;
    is_signed = (op == 2'b00) || (op == 2'b10);
    is_rem    = op[1];
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (is_signed) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return is_rem ? r : q;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic special;
    special = (b == 32'd0) ||
              (((op == 2'b00) || (op == 2'b10)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_SPECIAL_BYPASS_EN
    return special ? 1 : 33;
`else
    return special ? 33 : 33;
`endif
  endfunction

  task automatic idle_inputs();
    bus.start_i    = 1'b0;
    bus.flush_i    = 1'b0;
    bus.op_i       = 2'b00;
    bus.dividend_i = 32'd0;
    bus.divisor_i  = 32'd0;
    bus.rd_addr_i  = 5'd0;
  endtask

  // Called #1 after an edge with the unit IDLE; returns #1 after the edge following DONE.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int poke_at, input string tag);
    logic [31:0] exp;
    int lat;
    int exp_lat;
    exp_q.push_back(ref_div(op, a, b));
    exp_lat = ref_lat(op, a, b);
    bus.start_i    = 1'b1;
    bus.op_i       = op;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.rd_addr_i  = rd;
    @(posedge clk); #1;
    bus.start_i    = 1'b0;
    bus.dividend_i = $urandom;
    bus.divisor_i  = $urandom;
    bus.rd_addr_i  = 5'($urandom);
    lat = 1;
    while (bus.ready_o !== 1'b1 && lat < 100) begin
      n_checks++;
      if (bus.busy_o !== 1'b1) begin
        n_errors++;
        $display("FAIL %s busy at cycle %0d: got %b want 1", tag, lat, bus.busy_o);
      end
      if (lat == poke_at) begin
        bus.start_i    = 1'b1;
        bus.op_i       = 2'($urandom);
        bus.dividend_i = $urandom;
        bus.divisor_i  = $urandom_range(1, 1000);
      end else begin
        bus.start_i = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start_i = 1'b0;
    if (lat >= 100) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s timeout: no ready_o within %0d cycles", tag, lat);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      exp = exp_q.pop_front();
      n_checks++;
      if (lat !== exp_lat) begin
        n_errors++;
        $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
      end
      n_checks++;
      if (bus.result_o !== exp) begin
        n_errors++;
        $display("FAIL %s result: op=%0d a=%h b=%h got %h want %h", tag, op, a, b, bus.result_o, exp);
      end
      n_checks++;
      if (bus.rd_addr_o !== rd || bus.rd_wen_o !== 1'b1 || bus.busy_o !== 1'b1) begin
        n_errors++;
        $display("FAIL %s writeback: rd=%0d wen=%b busy=%b want rd=%0d wen=1 busy=1",
                 tag, bus.rd_addr_o, bus.rd_wen_o, bus.busy_o, rd);
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_o !== exp || bus.rd_addr_o !== rd) begin
        n_errors++;
        $display("FAIL %s after_done: ready=%b busy=%b result=%h rd=%0d want 0 0 %h %0d",
                 tag, bus.ready_o, bus.busy_o, bus.result_o, bus.rd_addr_o, exp, rd);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0 || bus.result_o !== 32'd0 ||
        bus.rd_addr_o !== 5'd0 || bus.rd_wen_o !== 1'b0 || bus.state_o !== DIV_IDLE) begin
      n_errors++;
      $display("FAIL reset_values: busy=%b ready=%b result=%h rd=%0d wen=%b state=%0d want all 0",
               bus.busy_o, bus.ready_o, bus.result_o, bus.rd_addr_o, bus.rd_wen_o, bus.state_o);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy_o !== 1'b0 || bus.state_o !== DIV_IDLE) begin
      n_errors++;
      $display("FAIL reset_release: busy=%b state=%0d want 0 IDLE", bus.busy_o, bus.state_o);
    end
  endtask

  task automatic test_directed();
    run_op(2'b01, 32'd100, 32'd7, 5'd3, 0, "divu_100_7");
    run_op(2'b11, 32'd100, 32'd7, 5'd4, 0, "remu_100_7");
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5, 0, "div_m7_2");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, "rem_m7_2");
    run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd7, 0, "div_7_m2");
    run_op(2'b01, 32'd5, 32'd0, 5'd8, 0, "divu_by0");
    run_op(2'b10, 32'd5, 32'd0, 5'd9, 0, "rem_by0");
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0, "div_ovf");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, "rem_ovf");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 5'd12, 0, "rem_neg_by0");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        3:       b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      run_op(2'($urandom_range(0, 3)), a, b, 5'($urandom), 0, "random");
    end
  endtask

  task automatic test_flush();
    logic saw_ready;
    // Flush on the 10th CALC cycle.
    bus.start_i = 1'b1; bus.op_i = 2'b01; bus.dividend_i = 32'd12345; bus.divisor_i = 32'd11;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.flush_i = 1'b1;
    n_checks++;
    if (bus.ready_o !== 1'b0 || bus.state_o !== DIV_CALC) begin
      n_errors++;
      $display("FAIL flush_calc_cycle: ready=%b state=%0d want 0 CALC", bus.ready_o, bus.state_o);
    end
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    saw_ready = bus.ready_o;
    n_checks++;
    if (bus.busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_calc_busy: got %b want 0", bus.busy_o);
    end
    @(posedge clk); #1;
    saw_ready = saw_ready | bus.ready_o;
    n_checks++;
    if (saw_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_calc_no_ready: got %b want 0", saw_ready);
    end
    run_op(2'b00, 32'hFFFF_0000, 32'd77, 5'd21, 0, "after_flush");

    // Flush while in DONE suppresses the writeback.
    bus.start_i = 1'b1; bus.op_i = 2'b11; bus.dividend_i = 32'd999; bus.divisor_i = 32'd10;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (32) begin @(posedge clk); #1; end
    bus.flush_i = 1'b1;
    #1;
    n_checks++;
    if (bus.state_o !== DIV_DONE || bus.ready_o !== 1'b0 || bus.rd_wen_o !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_done: state=%0d ready=%b wen=%b want DONE 0 0",
               bus.state_o, bus.ready_o, bus.rd_wen_o);
    end
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    n_checks++;
    if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_done_idle: busy=%b ready=%b want 0 0", bus.busy_o, bus.ready_o);
    end

    // Flush and start together in IDLE: nothing launches.
    bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.op_i = 2'b01; bus.dividend_i = 32'd50; bus.divisor_i = 32'd5;
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    saw_ready = 1'b0;
    n_checks++;
    if (bus.busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_start_busy: got %b want 0", bus.busy_o);
    end
    repeat (36) begin @(posedge clk); #1; saw_ready = saw_ready | bus.ready_o; end
    n_checks++;
    if (saw_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_start_no_ready: got %b want 0", saw_ready);
    end
  endtask

  task automatic test_start_ignored();
    run_op(2'b00, 32'hFFFF_FC18, 32'd7, 5'd17, 5, "start_ignored_a");
    run_op(2'b11, $urandom, $urandom_range(1, 300), 5'd18, 20, "start_ignored_b");
  endtask

  task automatic test_reset_mid_op();
    bus.start_i = 1'b1; bus.op_i = 2'b01; bus.dividend_i = 32'd4000; bus.divisor_i = 32'd3;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0 || bus.result_o !== 32'd0 ||
        bus.rd_addr_o !== 5'd0 || bus.rd_wen_o !== 1'b0 || bus.state_o !== DIV_IDLE) begin
      n_errors++;
      $display("FAIL reset_mid_op: busy=%b ready=%b result=%h rd=%0d wen=%b state=%0d want all 0",
               bus.busy_o, bus.ready_o, bus.result_o, bus.rd_addr_o, bus.rd_wen_o, bus.state_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(2'b00, 32'd1000, 32'hFFFF_FFFD, 5'd30, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_start_ignored();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
